// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: zero-fills the whole memory, then streams
// a length-prefixed image in from address 0 and releases the CPU reset once committed.
module imem_loader #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W:0]   len_i,
   input  logic [31:0]       data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [31:0]       wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              cpu_rst_o
);

   typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   state_t            state, state_n;
   logic [ADDR_W:0]   cnt, cnt_n, len_q, len_n;
   logic              we_n, done_n, cpu_rst_n;
   logic [ADDR_W-1:0] waddr_n;
   logic [31:0]       wdata_n;

   assign ready_o = (state == LOAD);
   assign busy_o  = (state == CLEAR) || (state == LOAD);

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      len_n     = len_q;
      we_n      = 1'b0;
      waddr_n   = waddr_o;
      wdata_n   = wdata_o;
      done_n    = done_o;
      cpu_rst_n = cpu_rst_o;
      case (state)
         IDLE, DONE: begin
            // outputs flip one cycle after DONE entry so the last write lands first
            if (state == DONE) begin
               done_n    = 1'b1;
               cpu_rst_n = 1'b0;
            end
            if (start_i) begin
               // the start edge already issues clear write 0
               done_n    = 1'b0;
               cpu_rst_n = 1'b1;
               len_n     = (len_i > DEPTH_C) ? DEPTH_C : len_i;
               cnt_n     = ONE_C;
               we_n      = 1'b1;
               waddr_n   = '0;
               wdata_n   = '0;
               state_n   = CLEAR;
            end
         end
         CLEAR: begin
            if (cnt == DEPTH_C) begin
               cnt_n   = '0;
               state_n = (len_q == '0) ? DONE : LOAD;
            end else begin
               we_n    = 1'b1;
               waddr_n = cnt[ADDR_W-1:0];
               wdata_n = '0;
               cnt_n   = cnt + ONE_C;
            end
         end
         LOAD: begin
            if (valid_i) begin
               we_n    = 1'b1;
               waddr_n = cnt[ADDR_W-1:0];
               wdata_n = data_i;
               cnt_n   = cnt + ONE_C;
               if (cnt == len_q - ONE_C) state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         len_q     <= '0;
         we_o      <= 1'b0;
         waddr_o   <= '0;
         wdata_o   <= '0;
         done_o    <= 1'b0;
         cpu_rst_o <= 1'b1;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         len_q     <= len_n;
         we_o      <= we_n;
         waddr_o   <= waddr_n;
         wdata_o   <= wdata_n;
         done_o    <= done_n;
         cpu_rst_o <= cpu_rst_n;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clear sweep, load handshake, clamping,
// mid-load reset and start handling in LOAD/DONE.
module tb_imem_loader;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst_i, start_i, valid_i;
   logic [ADDR_W:0]   len_i;
   logic [31:0]       data_i;
   logic              ready_o, we_o, busy_o, done_o, cpu_rst_o;
   logic [ADDR_W-1:0] waddr_o;
   logic [31:0]       wdata_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [ADDR_W-1:0] wa_q[$];
   logic [31:0]       wd_q[$];
   int                wc_q[$];

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
      .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .we_o(we_o),
      .waddr_o(waddr_o), .wdata_o(wdata_o), .busy_o(busy_o), .done_o(done_o),
      .cpu_rst_o(cpu_rst_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // write log, sampled mid-cycle; cyc is the edge number that produced the write
   always @(negedge clk) begin
      if (we_o === 1'b1) begin
         wa_q.push_back(waddr_o);
         wd_q.push_back(wdata_o);
         wc_q.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_log();
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
   endtask

   task automatic do_start(input int len);
      start_i = 1'b1;
      len_i   = (ADDR_W+1)'(len);
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (ready_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic accept(input logic [31:0] d);
      valid_i = 1'b1;
      data_i  = d;
      tick();
      valid_i = 1'b0;
   endtask

   // number of malformed entries among the first DEPTH logged writes (clear sweep from edge t0)
   function automatic int clear_bad(input int t0);
      int bad = 0;
      if (wa_q.size() < DEPTH) return 9999;
      for (int i = 0; i < DEPTH; i++)
         if (wa_q[i] !== ADDR_W'(i) || wd_q[i] !== 32'h0 || wc_q[i] != t0 + i) bad++;
      return bad;
   endfunction

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0; valid_i = 1'b0; len_i = '0; data_i = '0;
      tick(); tick();
      checks++; if (ready_o !== 1'b0)     begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
      checks++; if (we_o !== 1'b0)        begin errors++; $display("FAIL reset_we: got %b want 0", we_o); end
      checks++; if (waddr_o !== '0)       begin errors++; $display("FAIL reset_waddr: got %h want 0", waddr_o); end
      checks++; if (wdata_o !== '0)       begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata_o); end
      checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if (done_o !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
      checks++; if (cpu_rst_o !== 1'b1)   begin errors++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst_o); end
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [31:0] w[3] = '{32'h00500093, 32'h00600113, 32'h002081B3};
      int t0, idx, n, bad;
      clr_log();
      valid_i = 1'b1;
      data_i  = w[0];
      do_start(3);
      t0 = cyc;
      checks++; if ({we_o, busy_o, ready_o} !== 3'b110 || waddr_o !== '0)
         begin errors++; $display("FAIL basic_first_clear: got we/busy/ready %b%b%b addr %h want 110 addr 00", we_o, busy_o, ready_o, waddr_o); end
      idx = 0; n = 0;
      while (idx < 3 && n < 400) begin
         if (ready_o === 1'b1) begin
            tick();
            idx++;
            if (idx < 3) data_i = w[idx];
         end else tick();
         n++;
      end
      checks++; if (idx != 3) begin errors++; $display("FAIL basic_accepts: got %0d want 3", idx); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_drop: got %b want 0", ready_o); end
      checks++; if (we_o !== 1'b1 || waddr_o !== 8'd2 || wdata_o !== w[2])
         begin errors++; $display("FAIL basic_last_write: got we %b addr %h data %h want 1 02 %h", we_o, waddr_o, wdata_o, w[2]); end
      checks++; if (done_o !== 1'b0 || cpu_rst_o !== 1'b1)
         begin errors++; $display("FAIL basic_done_early: got done %b cpu_rst %b want 0 1", done_o, cpu_rst_o); end
      valid_i = 1'b0;
      tick();
      checks++; if (done_o !== 1'b1 || cpu_rst_o !== 1'b0 || busy_o !== 1'b0)
         begin errors++; $display("FAIL basic_done: got done %b cpu_rst %b busy %b want 1 0 0", done_o, cpu_rst_o, busy_o); end
      bad = clear_bad(t0);
      checks++; if (bad != 0) begin errors++; $display("FAIL basic_clear_sweep: got %0d bad entries want 0", bad); end
      bad = 0;
      if (wa_q.size() != DEPTH + 3) bad = 9999;
      else for (int k = 0; k < 3; k++)
         if (wa_q[DEPTH+k] !== ADDR_W'(k) || wd_q[DEPTH+k] !== w[k] || wc_q[DEPTH+k] != t0 + 257 + k) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL basic_load_writes: got %0d bad (log size %0d) want 0", bad, wa_q.size()); end
   endtask

   task automatic test_gaps();
      logic [31:0] w[4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      int gaps[4] = '{0, 2, 5, 0};
      int bad;
      bit ok;
      clr_log();
      do_start(4);
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL gaps_ready_timeout: got 0 want 1"); end
      for (int k = 0; k < 4; k++) begin
         accept(w[k]);
         checks++; if (we_o !== 1'b1 || waddr_o !== ADDR_W'(k) || wdata_o !== w[k])
            begin errors++; $display("FAIL gaps_write%0d: got we %b addr %h data %h want 1 %h %h", k, we_o, waddr_o, wdata_o, ADDR_W'(k), w[k]); end
         for (int g = 0; g < gaps[k]; g++) begin
            tick();
            checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL gaps_idle_we: got %b want 0", we_o); end
         end
      end
      tick();
      checks++; if (done_o !== 1'b1 || cpu_rst_o !== 1'b0)
         begin errors++; $display("FAIL gaps_done: got done %b cpu_rst %b want 1 0", done_o, cpu_rst_o); end
      bad = 0;
      if (wa_q.size() != DEPTH + 4) bad = 9999;
      else for (int k = 0; k < 4; k++)
         if (wa_q[DEPTH+k] !== ADDR_W'(k) || wd_q[DEPTH+k] !== w[k]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL gaps_log: got %0d bad (log size %0d) want 0", bad, wa_q.size()); end
   endtask

   task automatic test_len0();
      int t0, bad;
      bit saw_ready = 1'b0;
      clr_log();
      valid_i = 1'b1;
      data_i  = 32'hDEADBEEF;
      do_start(0);
      t0 = cyc;
      for (int k = 1; k <= 260; k++) begin
         if (ready_o === 1'b1) saw_ready = 1'b1;
         if (k == 257) begin
            checks++; if (cpu_rst_o !== 1'b1 || done_o !== 1'b0)
               begin errors++; $display("FAIL len0_t257: got cpu_rst %b done %b want 1 0", cpu_rst_o, done_o); end
         end
         if (k == 258) begin
            checks++; if (cpu_rst_o !== 1'b0 || done_o !== 1'b1)
               begin errors++; $display("FAIL len0_t258: got cpu_rst %b done %b want 0 1", cpu_rst_o, done_o); end
         end
         tick();
      end
      valid_i = 1'b0;
      checks++; if (saw_ready) begin errors++; $display("FAIL len0_ready_pulse: got 1 want 0"); end
      checks++; if (wa_q.size() != DEPTH) begin errors++; $display("FAIL len0_write_count: got %0d want %0d", wa_q.size(), DEPTH); end
      bad = clear_bad(t0);
      checks++; if (bad != 0) begin errors++; $display("FAIL len0_clear_sweep: got %0d bad want 0", bad); end
   endtask

   task automatic test_clamp();
      int idx, n, bad, zeros;
      clr_log();
      valid_i = 1'b1;
      data_i  = 32'h1000;
      do_start(300);
      idx = 0; n = 0;
      while (n < 800) begin
         if (ready_o === 1'b1) begin
            tick();
            idx++;
            data_i = 32'h1000 + idx;
         end else if (idx > 0) break;
         else tick();
         n++;
      end
      checks++; if (idx != DEPTH) begin errors++; $display("FAIL clamp_accepts: got %0d want %0d", idx, DEPTH); end
      tick(); tick(); tick();
      valid_i = 1'b0;
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL clamp_done: got %b want 1", done_o); end
      checks++; if (wa_q.size() != 2 * DEPTH) begin errors++; $display("FAIL clamp_write_count: got %0d want %0d", wa_q.size(), 2 * DEPTH); end
      bad = 0; zeros = 0;
      for (int k = DEPTH; k < wa_q.size(); k++) begin
         if (wa_q[k] === '0) zeros++;
         if (wa_q[k] !== ADDR_W'(k - DEPTH) || wd_q[k] !== 32'h1000 + (k - DEPTH)) bad++;
      end
      checks++; if (zeros != 1) begin errors++; $display("FAIL clamp_addr0_writes: got %0d want 1", zeros); end
      checks++; if (bad != 0) begin errors++; $display("FAIL clamp_load_seq: got %0d bad want 0", bad); end
      checks++; if (wa_q.size() == 0 || wa_q[wa_q.size()-1] !== 8'hFF || wd_q[wd_q.size()-1] !== 32'h10FF)
         begin errors++; $display("FAIL clamp_last_write: log size %0d want last 0xff:0x000010ff", wa_q.size()); end
   endtask

   task automatic test_reset_mid();
      int t0, bad;
      bit ok;
      clr_log();
      do_start(5);
      wait_ready(ok);
      accept(32'hA0A0A0A0);
      accept(32'hB1B1B1B1);
      rst_i = 1'b1;
      tick();
      checks++; if ({ready_o, we_o, cpu_rst_o, busy_o, done_o} !== 5'b00100)
         begin errors++; $display("FAIL midrst_outputs: got rdy/we/cpurst/busy/done %b%b%b%b%b want 00100", ready_o, we_o, cpu_rst_o, busy_o, done_o); end
      rst_i = 1'b0;
      tick();
      clr_log();
      do_start(2);
      t0 = cyc;
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL midrst_ready_timeout: got 0 want 1"); end
      accept(32'hC2C2C2C2);
      accept(32'hD3D3D3D3);
      tick();
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b want 1", done_o); end
      bad = clear_bad(t0);
      if (wa_q.size() != DEPTH + 2) bad += 1000;
      else if (wa_q[DEPTH] !== 8'h00 || wd_q[DEPTH] !== 32'hC2C2C2C2 ||
               wa_q[DEPTH+1] !== 8'h01 || wd_q[DEPTH+1] !== 32'hD3D3D3D3) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL midrst_reload_log: got %0d bad (log size %0d) want 0", bad, wa_q.size()); end
   endtask

   task automatic test_start_ignored_and_reload();
      int t0, bad;
      bit ok;
      clr_log();
      do_start(3);
      wait_ready(ok);
      accept(32'h0000_0001);
      start_i = 1'b1;
      len_i   = 9'd1;
      tick();
      start_i = 1'b0;
      checks++; if ({ready_o, busy_o, we_o} !== 3'b110)
         begin errors++; $display("FAIL load_start_ignored: got rdy/busy/we %b%b%b want 110", ready_o, busy_o, we_o); end
      accept(32'h0000_0002);
      accept(32'h0000_0003);
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL load_len_kept: got ready %b want 0", ready_o); end
      tick();
      checks++; if (done_o !== 1'b1 || cpu_rst_o !== 1'b0)
         begin errors++; $display("FAIL load_done: got done %b cpu_rst %b want 1 0", done_o, cpu_rst_o); end
      clr_log();
      start_i = 1'b1;
      len_i   = 9'd1;
      tick();
      start_i = 1'b0;
      t0 = cyc;
      checks++; if ({cpu_rst_o, done_o, we_o, busy_o} !== 4'b1011 || waddr_o !== '0)
         begin errors++; $display("FAIL reload_entry: got cpurst/done/we/busy %b%b%b%b addr %h want 1011 00", cpu_rst_o, done_o, we_o, busy_o, waddr_o); end
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL reload_ready_timeout: got 0 want 1"); end
      bad = clear_bad(t0);
      if (wa_q.size() != DEPTH) bad += 1000;
      checks++; if (bad != 0) begin errors++; $display("FAIL reload_clear: got %0d bad (log size %0d) want 0", bad, wa_q.size()); end
      accept(32'hCAFEF00D);
      tick();
      checks++; if (done_o !== 1'b1 || wa_q.size() != DEPTH + 1 || wd_q[wd_q.size()-1] !== 32'hCAFEF00D)
         begin errors++; $display("FAIL reload_load: got done %b log size %0d want 1 %0d", done_o, wa_q.size(), DEPTH + 1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_len0();
      test_clamp();
      test_reset_mid();
      test_start_ignored_and_reload();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
